// File: rtl/seed_entropy_source.sv
// Entropy producer for the Zkr `seed` CSR: samples a raw noise bit, runs
// repetition-count and adaptive-proportion health tests, and packs 16 raw bits.
module seed_entropy_source #(
    parameter int SAMPLE_DIV  = 4,
    parameter int BIST_CYCLES = 64,
    parameter int RCT_CUTOFF  = 32,
    parameter int APT_WINDOW  = 512,
    parameter int APT_CUTOFF  = 410
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        noise_i,
    input  logic        csr_rd_i,
    output logic [31:0] csr_rdata_o,
    output logic        es16_o,
    output logic        dead_o
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W  = $clog2(RCT_CUTOFF + 1);
    localparam int APT_W  = $clog2(APT_WINDOW + 1);
    localparam int BIST_W = $clog2(BIST_CYCLES + 1);
    localparam int CNT_W  = 5;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0]  RUN_CUT   = RUN_W'(RCT_CUTOFF);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [APT_W-1:0]  APT_WIN   = APT_W'(APT_WINDOW);
    localparam logic [APT_W-1:0]  APT_HI    = APT_W'(APT_CUTOFF);
    localparam logic [APT_W-1:0]  APT_LO    = APT_W'(APT_WINDOW - APT_CUTOFF);
    localparam logic [BIST_W-1:0] BIST_DONE = BIST_W'(BIST_CYCLES);
    localparam logic [CNT_W-1:0]  POOL_FULL = CNT_W'(16);

    typedef enum logic [1:0] {
        ST_BIST = 2'b00,
        ST_WAIT = 2'b01,
        ST_ES16 = 2'b10,
        ST_DEAD = 2'b11
    } state_t;

    // Saturating increments: every counter holds at all-ones instead of wrapping.
    function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [APT_W-1:0] sat_inc_apt(input logic [APT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [BIST_W-1:0] sat_inc_bist(input logic [BIST_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              last_q, last_d;
    logic [APT_W-1:0]  ones_q, ones_d;
    logic [APT_W-1:0]  win_q, win_d;
    logic [BIST_W-1:0] bist_q, bist_d;
    logic [15:0]       pool_q, pool_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              strobe;
    logic              rct_fail;
    logic              apt_fail;
    logic              health_fail;
    logic [APT_W-1:0]  ones_n;
    logic [APT_W-1:0]  win_n;
    logic [15:0]       entropy;
    logic [1:0]        opst;

    // Sample divider; frozen once the source is dead.
    always_comb begin
        strobe = (state_q != ST_DEAD) && (div_q == DIV_LAST);
        div_d  = div_q;
        if (state_q != ST_DEAD) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    // Continuous health tests evaluated on every strobe, regardless of pooling.
    always_comb begin
        run_d    = run_q;
        last_d   = last_q;
        ones_d   = ones_q;
        win_d    = win_q;
        ones_n   = ones_q;
        win_n    = win_q;
        rct_fail = 1'b0;
        apt_fail = 1'b0;
        if (strobe) begin
            last_d = noise_i;
            if ((run_q == '0) || (noise_i != last_q)) begin
                run_d = RUN_ONE;
            end else begin
                run_d = sat_inc_run(run_q);
            end
            rct_fail = (run_d >= RUN_CUT);

            ones_n = noise_i ? sat_inc_apt(ones_q) : ones_q;
            win_n  = sat_inc_apt(win_q);
            if (win_n == APT_WIN) begin
                apt_fail = (ones_n >= APT_HI) || (ones_n <= APT_LO);
                ones_d   = '0;
                win_d    = '0;
            end else begin
                ones_d = ones_n;
                win_d  = win_n;
            end
        end
        health_fail = rct_fail | apt_fail;
    end

    always_comb begin
        state_d = state_q;
        bist_d  = bist_q;
        pool_d  = pool_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BIST: begin
                if (strobe) begin
                    if (health_fail) begin
                        state_d = ST_DEAD;
                    end else begin
                        bist_d = sat_inc_bist(bist_q);
                        if (bist_d == BIST_DONE) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (strobe) begin
                    if (health_fail) begin
                        state_d = ST_DEAD;
                    end else begin
                        pool_d = {pool_q[14:0], noise_i};
                        cnt_d  = sat_inc_cnt(cnt_q);
                        if (cnt_d == POOL_FULL) begin
                            state_d = ST_ES16;
                        end
                    end
                end
            end
            ST_ES16: begin
                // A failure outranks the wipe; the read still sees this cycle's pool.
                if (strobe && health_fail) begin
                    state_d = ST_DEAD;
                end else if (csr_rd_i) begin
                    state_d = ST_WAIT;
                    pool_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_DEAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BIST;
            div_q   <= '0;
            run_q   <= '0;
            last_q  <= 1'b0;
            ones_q  <= '0;
            win_q   <= '0;
            bist_q  <= '0;
            pool_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            run_q   <= run_d;
            last_q  <= last_d;
            ones_q  <= ones_d;
            win_q   <= win_d;
            bist_q  <= bist_d;
            pool_q  <= pool_d;
            cnt_q   <= cnt_d;
        end
    end

    // Partial pools never leave the block.
    assign opst        = state_q;
    assign entropy     = (state_q == ST_ES16) ? pool_q : 16'h0000;
    assign csr_rdata_o = {opst, 6'b000000, 8'h00, entropy};
    assign es16_o      = (state_q == ST_ES16);
    assign dead_o      = (state_q == ST_DEAD);

endmodule
